tis_port_unit: RTL and testbench
================================

// Module: tis_port_unit
// PURPOSE
//  Blocking neighbour-port transfer unit of one TIS-100 node; consumes the decoded MOV/port fields from the fetch/jump stage.
//  Runs the read/write handshake with UP/RIGHT/DOWN/LEFT, resolves ANY/LAST/NIL, returns the read value.
//  Drives hlt (freezes IP while blocked) and ackw (one-cycle release) back to the fetch/jump stage.
// PARAMETERS
//  DATA_W  11  node word width (two's complement, -999..999)
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-high
//  req        in   1         port op request; sampled only in IDLE
//  rd_en      in   1         op has a port source
//  wr_en      in   1         op has a port destination
//  rd_sel     in   3         source: 0 UP,1 RIGHT,2 DOWN,3 LEFT,4 ANY,5 LAST,6 NIL,7 =NIL
//  wr_sel     in   3         destination, same encoding
//  wr_data    in   DATA_W    write value when rd_en=0 (captured at req)
//  in_valid   in   4         neighbour offers word, idx = dir code
//  in_data    in   4*DATA_W  neighbour words, dir d at [d*DATA_W +: DATA_W]
//  in_ack     out  4         accept pulse to neighbour; at most one bit high
//  out_valid  out  4         word offered to neighbour; at most one bit high
//  out_data   out  DATA_W    word offered (shared by all dirs)
//  out_ack    in   4         neighbour accept pulse
//  rd_data    out  DATA_W    read result; registered, stable from ackw to next req
//  hlt        out  1         high while op in progress
//  ackw       out  1         one-cycle completion pulse
// BEHAVIOUR
//  Reset (async): state IDLE; in_ack, out_valid, out_data, rd_data, hlt, ackw =0; last_valid=0; any_ptr=LEFT.
//  Transfer on dir d = valid&ack on d in the same cycle; data owned by sender until then.
//  States: IDLE, RD_WAIT, WR_WAIT, DONE.
//  IDLE: req&rd_en -> RD_WAIT; req&wr_en&!rd_en -> WR_WAIT (wr_data latched); else stay.
//   req with rd_en=wr_en=0 -> DONE (no-op). hlt=1 in every state except IDLE and DONE.
//  RD_WAIT: in_ack[d] combinational from in_valid and sel only (never from out_*).
//   fixed dir: in_ack[d]=in_valid[d]. ANY: highest-priority valid, order LEFT>RIGHT>UP>DOWN.
//   LAST: last_dir if last_valid, else as NIL. NIL: no handshake, value 0, leave in 1 cycle.
//   on transfer: rd_data<=word; ANY also sets last_dir, last_valid=1; next WR_WAIT if wr_en (payload=read word) else DONE.
//  WR_WAIT: out_data=payload; out_valid driven from registers only.
//   fixed dir: out_valid[d]=1 until out_ack[d]. ANY: one dir per cycle, rotating LEFT,RIGHT,UP,DOWN from any_ptr;
//   completes on ack of currently offered dir; last_dir updated, any_ptr resets to LEFT. Acks on unoffered dirs ignored.
//   LAST/NIL rules as read: NIL discards payload, leaves in 1 cycle.
//  DONE: ackw=1, hlt=0, all valid/ack=0; -> IDLE unconditionally. req in non-IDLE states ignored.
//  Latency req->ackw: NIL/no-op 2 cycles; read or write with ready neighbour 3; MOV port,port ready 4. Unbounded wait, no timeout.
//  hlt is low for >=1 cycle (DONE) between consecutive ops -> fresh rising edge each op.
//  rd_data unchanged by writes and NIL writes; NIL read sets rd_data=0.
//  Reset mid-op: abandon op, outputs to reset values immediately; no partial transfer completes.
// STRUCTURE
//  tis100_pkg: DIR_UP..DIR_LEFT, SEL_ANY/LAST/NIL codes, ANY priority order, state encoding, DATA_W default.
//  Sub-module tis_any_prio: 4-bit request -> one-hot grant + 2-bit dir, fixed LEFT>RIGHT>UP>DOWN.
//  Rest: one FSM, payload reg, rd_data reg, last_dir/last_valid, any_ptr.
// TESTING
//  1 req rd UP, in_valid[0] already high data 42 -> in_ack[0] cycle 1, ackw cycle 2, rd_data=42, hlt high cycle 1 only.
//  2 req wr RIGHT data -7, out_ack[1] held off 5 cycles -> out_valid[1] steady, out_data=-7, ackw 1 cycle after ack.
//  3 rd ANY, in_valid UP,DOWN,LEFT high same cycle -> only in_ack[3]; then rd LAST -> waits on LEFT only.
//  4 MOV UP,DOWN: UP supplies 999 -> out_valid[2] with 999 next cycle; ack -> ackw; total 4 cycles if ready.
//  5 wr ANY, only DOWN acks -> offers rotate L,R,U,D; done on DOWN; rd LAST before any ANY ever -> 0 in 2 cycles.
//  6 reset asserted during WR_WAIT -> out_valid=0, hlt=0, ackw never pulses; next req behaves as from reset.

Source files
------------

// File: rtl/tis100_pkg.sv
// Shared definitions for the TIS-100 node port unit.
//   - direction codes (index into in_valid/in_ack/out_valid/out_ack)
//   - virtual port selector codes (ANY, LAST, NIL)
//   - ANY read priority order and ANY write rotation
//   - port FSM state encoding
package tis100_pkg;

    localparam int DATA_W_DEF = 11;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [2:0] SEL_ANY     = 3'd4;
    localparam logic [2:0] SEL_LAST    = 3'd5;
    localparam logic [2:0] SEL_NIL     = 3'd6;
    localparam logic [2:0] SEL_NIL_ALT = 3'd7;

    // ANY priority, highest first: entry i lives at [i*2 +: 2].
    localparam logic [7:0] ANY_PRIO = {DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } port_state_e;

    // LAST with no recorded ANY partner behaves exactly like NIL.
    function automatic logic sel_is_nil(input logic [2:0] sel, input logic last_valid);
        return (sel == SEL_NIL) || (sel == SEL_NIL_ALT) || ((sel == SEL_LAST) && !last_valid);
    endfunction

    // ANY write offers walk the same order as the read priority.
    function automatic logic [1:0] any_rot_next(input logic [1:0] dir);
        case (dir)
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_UP;
            DIR_UP:    return DIR_DOWN;
            default:   return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/tis_any_prio.sv
// Fixed-priority arbiter for ANY reads, order LEFT > RIGHT > UP > DOWN.
//   req_i  : per-direction valid (index = dir code)
//   gnt_o  : one-hot grant, zero when no request
//   dir_o  : granted direction code (LEFT when no request)
//   any_o  : at least one request present
module tis_any_prio
    import tis100_pkg::*;
(
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] dir_o,
    output logic       any_o
);

    logic [1:0] cand;

    always_comb begin
        gnt_o = '0;
        dir_o = DIR_LEFT;
        any_o = |req_i;
        cand  = '0;
        // Walk lowest priority first so the highest-priority hit wins.
        for (int i = 3; i >= 0; i--) begin
            cand = ANY_PRIO[i*2 +: 2];
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                dir_o       = cand;
            end
        end
    end

endmodule

// File: rtl/tis_port_unit.sv
// Blocking neighbour-port transfer unit of one TIS-100 node.
// Runs the read/write handshakes for a decoded MOV, resolves ANY/LAST/NIL,
// and reports hlt/ackw back to the fetch/jump stage.
//   clk_i, reset_i          : clock, async active-high reset
//   req_i, rd_en_i, wr_en_i : op request and which sides use a port
//   rd_sel_i, wr_sel_i      : port selectors (0..3 dir, 4 ANY, 5 LAST, 6/7 NIL)
//   wr_data_i               : write value for write-only ops
//   in_valid_i/in_data_i    : neighbour offers;  in_ack_o : accept pulse
//   out_valid_o/out_data_o  : our offer;         out_ack_i : neighbour accept
//   rd_data_o               : last read result
//   hlt_o, ackw_o           : busy level, one-cycle completion pulse
//
// state      | meaning
// ST_IDLE    | waiting for req; NIL/no-op sides resolved here
// ST_RD_WAIT | accepting a word from the selected neighbour
// ST_WR_WAIT | offering payload to the selected neighbour
// ST_DONE    | ackw pulse, hlt low, back to idle
module tis_port_unit
    import tis100_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic                rd_en_i,
    input  logic                wr_en_i,
    input  logic [2:0]          rd_sel_i,
    input  logic [2:0]          wr_sel_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [3:0]          in_valid_i,
    input  logic [4*DATA_W-1:0] in_data_i,
    output logic [3:0]          in_ack_o,
    output logic [3:0]          out_valid_o,
    output logic [DATA_W-1:0]   out_data_o,
    input  logic [3:0]          out_ack_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                hlt_o,
    output logic                ackw_o
);

    port_state_e       state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [2:0]        rd_sel_q, rd_sel_d;
    logic [2:0]        wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        last_dir_q, last_dir_d;
    logic              last_valid_q, last_valid_d;
    logic [1:0]        any_ptr_q, any_ptr_d;

    logic [3:0]        prio_gnt;
    logic [1:0]        prio_dir;
    logic              prio_any;

    logic [1:0]        rd_dir;
    logic              rd_xfer;
    logic [DATA_W-1:0] rd_word;
    logic              last_valid_after;
    logic [1:0]        wr_dir;

    tis_any_prio u_any_prio (
        .req_i (in_valid_i),
        .gnt_o (prio_gnt),
        .dir_o (prio_dir),
        .any_o (prio_any)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            rd_sel_q     <= SEL_NIL;
            wr_sel_q     <= SEL_NIL;
            payload_q    <= '0;
            rd_data_q    <= '0;
            last_dir_q   <= DIR_LEFT;
            last_valid_q <= 1'b0;
            any_ptr_q    <= DIR_LEFT;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            rd_sel_q     <= rd_sel_d;
            wr_sel_q     <= wr_sel_d;
            payload_q    <= payload_d;
            rd_data_q    <= rd_data_d;
            last_dir_q   <= last_dir_d;
            last_valid_q <= last_valid_d;
            any_ptr_q    <= any_ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q;
        rd_sel_d     = rd_sel_q;
        wr_sel_d     = wr_sel_q;
        payload_d    = payload_q;
        rd_data_d    = rd_data_q;
        last_dir_d   = last_dir_q;
        last_valid_d = last_valid_q;
        any_ptr_d    = any_ptr_q;
        in_ack_o     = '0;
        out_valid_o  = '0;

        // Read side: only RD_WAIT uses these; NIL reads never reach it.
        if (rd_sel_q == SEL_ANY) begin
            rd_dir  = prio_dir;
            rd_xfer = prio_any;
        end else begin
            rd_dir  = (rd_sel_q == SEL_LAST) ? last_dir_q : rd_sel_q[1:0];
            rd_xfer = in_valid_i[rd_dir];
        end
        rd_word          = in_data_i[int'(rd_dir)*DATA_W +: DATA_W];
        last_valid_after = (rd_sel_q == SEL_ANY) ? 1'b1 : last_valid_q;

        // Write side: decoded purely from registers.
        if (wr_sel_q == SEL_ANY) begin
            wr_dir = any_ptr_q;
        end else if (wr_sel_q == SEL_LAST) begin
            wr_dir = last_dir_q;
        end else begin
            wr_dir = wr_sel_q[1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    wr_en_d  = wr_en_i;
                    rd_sel_d = rd_sel_i;
                    wr_sel_d = wr_sel_i;
                    if (rd_en_i) begin
                        if (sel_is_nil(rd_sel_i, last_valid_q)) begin
                            // NIL read yields 0 without any handshake.
                            rd_data_d = '0;
                            if (wr_en_i && !sel_is_nil(wr_sel_i, last_valid_q)) begin
                                payload_d = '0;
                                state_d   = ST_WR_WAIT;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end else if (wr_en_i) begin
                        if (sel_is_nil(wr_sel_i, last_valid_q)) begin
                            state_d = ST_DONE;
                        end else begin
                            payload_d = wr_data_i;
                            state_d   = ST_WR_WAIT;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RD_WAIT: begin
                if (rd_sel_q == SEL_ANY) begin
                    in_ack_o = prio_gnt;
                end else begin
                    in_ack_o[rd_dir] = in_valid_i[rd_dir];
                end
                if (rd_xfer) begin
                    rd_data_d = rd_word;
                    if (rd_sel_q == SEL_ANY) begin
                        last_dir_d   = rd_dir;
                        last_valid_d = 1'b1;
                    end
                    // Write LAST sees the partner this read may have just set.
                    if (wr_en_q && !sel_is_nil(wr_sel_q, last_valid_after)) begin
                        payload_d = rd_word;
                        state_d   = ST_WR_WAIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WR_WAIT: begin
                out_valid_o[wr_dir] = 1'b1;
                if (out_ack_i[wr_dir]) begin
                    state_d = ST_DONE;
                    if (wr_sel_q == SEL_ANY) begin
                        last_dir_d   = wr_dir;
                        last_valid_d = 1'b1;
                        any_ptr_d    = DIR_LEFT;
                    end
                end else if (wr_sel_q == SEL_ANY) begin
                    any_ptr_d = any_rot_next(any_ptr_q);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_data_o = payload_q;
    assign rd_data_o  = rd_data_q;
    assign hlt_o      = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    assign ackw_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_tis_port_unit.sv
module tb_tis_port_unit;

    localparam int DW = 11;
    // ANY order, highest priority first: LEFT, RIGHT, UP, DOWN.
    localparam int ROT[4] = '{3, 1, 0, 2};
    localparam int K_RD = 0, K_WR = 1, K_FIN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
    logic [2:0]    rd_sel = 3'd0, wr_sel = 3'd0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    in_valid = '0;
    logic [4*DW-1:0] in_data = '0;
    logic [3:0]    in_ack;
    logic [3:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_ack = '0;
    logic [DW-1:0] rd_data;
    logic          hlt, ackw;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    tis_port_unit #(.DATA_W(DW)) dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .rd_en_i(rd_en), .wr_en_i(wr_en),
        .rd_sel_i(rd_sel), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ack_o(in_ack),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ack_i(out_ack),
        .rd_data_o(rd_data), .hlt_o(hlt), .ackw_o(ackw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An op is a list of remaining steps; NIL steps are never queued.
    typedef struct { int kind; int sel; } step_t;
    typedef struct {
        logic [3:0] in_ack; logic [3:0] out_valid; logic hlt; logic ackw;
        logic xfer; logic [DW-1:0] word; int dir;
    } exp_t;

    step_t         q[$];
    logic [DW-1:0] m_rd_data = '0;
    logic [DW-1:0] m_payload = '0;
    int            m_last_dir = 3;
    bit            m_last_valid = 1'b0;
    int            m_any_idx = 0;
    exp_t          e_cmp;
    exp_t          e_mdl;

    function automatic bit is_nil(int s);
        return (s == 6) || (s == 7) || (s == 5 && !m_last_valid);
    endfunction

    function automatic exp_t model_now();
        exp_t e;
        int d;
        e.in_ack = '0; e.out_valid = '0; e.hlt = 0; e.ackw = 0;
        e.xfer = 0; e.word = '0; e.dir = -1;
        if (q.size() == 0) return e;
        if (q[0].kind == K_FIN) begin
            e.ackw = 1;
        end else if (q[0].kind == K_RD) begin
            e.hlt = 1;
            d = -1;
            if (q[0].sel == 4) begin
                for (int k = 0; k < 4; k++) if (d < 0 && in_valid[ROT[k]]) d = ROT[k];
            end else if (q[0].sel == 5) d = m_last_dir;
            else d = q[0].sel;
            if (d >= 0 && in_valid[d]) begin
                e.in_ack[d] = 1; e.xfer = 1; e.dir = d;
                e.word = in_data[d*DW +: DW];
            end
        end else begin
            e.hlt = 1;
            if (q[0].sel == 4) d = ROT[m_any_idx];
            else if (q[0].sel == 5) d = m_last_dir;
            else d = q[0].sel;
            e.out_valid[d] = 1; e.xfer = out_ack[d]; e.dir = d;
        end
        return e;
    endfunction

    function automatic void drop_nil_writes();
        while (q.size() > 0 && q[0].kind == K_WR && is_nil(q[0].sel)) void'(q.pop_front());
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_rd_data = '0; m_payload = '0;
            m_last_dir = 3; m_last_valid = 0; m_any_idx = 0;
        end else begin
            e_mdl = model_now();
            if (q.size() == 0) begin
                if (req) begin
                    if (rd_en) begin
                        if (is_nil(int'(rd_sel))) begin
                            m_rd_data = '0; m_payload = '0;
                        end else q.push_back('{kind: K_RD, sel: int'(rd_sel)});
                    end
                    if (wr_en) begin
                        q.push_back('{kind: K_WR, sel: int'(wr_sel)});
                        if (!rd_en) m_payload = wr_data;
                    end
                    q.push_back('{kind: K_FIN, sel: 0});
                    drop_nil_writes();
                end
            end else if (q[0].kind == K_FIN) begin
                void'(q.pop_front());
            end else if (q[0].kind == K_RD) begin
                if (e_mdl.xfer) begin
                    m_rd_data = e_mdl.word;
                    m_payload = e_mdl.word;
                    if (q[0].sel == 4) begin m_last_dir = e_mdl.dir; m_last_valid = 1; end
                    void'(q.pop_front());
                    drop_nil_writes();
                end
            end else begin
                if (e_mdl.xfer) begin
                    if (q[0].sel == 4) begin
                        m_last_dir = e_mdl.dir; m_last_valid = 1; m_any_idx = 0;
                    end
                    void'(q.pop_front());
                end else if (q[0].sel == 4) begin
                    m_any_idx = (m_any_idx + 1) % 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            e_cmp = model_now();
            chk("in_ack", 32'(in_ack), 32'(e_cmp.in_ack));
            chk("out_valid", 32'(out_valid), 32'(e_cmp.out_valid));
            chk("hlt", 32'(hlt), 32'(e_cmp.hlt));
            chk("ackw", 32'(ackw), 32'(e_cmp.ackw));
            chk("rd_data", 32'(rd_data), 32'(m_rd_data));
            if (e_cmp.out_valid != 4'b0) chk("out_data", 32'(out_data), 32'(m_payload));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_in();
        req = 0; rd_en = 0; wr_en = 0; rd_sel = 0; wr_sel = 0; wr_data = '0;
        in_valid = '0; in_data = '0; out_ack = '0;
    endtask

    task automatic set_word(input int d, input int v);
        in_data[d*DW +: DW] = DW'(v);
    endtask

    task automatic issue(input bit r, input bit w, input int rs, input int ws, input int wd);
        req = 1; rd_en = r; wr_en = w; rd_sel = 3'(rs); wr_sel = 3'(ws); wr_data = DW'(wd);
    endtask

    initial begin
        #1 rst = 1;
        started = 1;
        repeat (2) tick();
        chk("reset_out_data", 32'(out_data), 32'd0);
        rst = 0;
        tick();

        // T1: read UP, word already offered.
        in_valid = 4'b0001; set_word(0, 42); issue(1, 0, 0, 0, 0);
        tick(); req = 0; @(negedge clk);
        chk("t1_in_ack", 32'(in_ack), 32'h1);
        chk("t1_hlt", 32'(hlt), 32'h1);
        tick(); in_valid = 0; @(negedge clk);
        chk("t1_ackw", 32'(ackw), 32'h1);
        chk("t1_hlt_low", 32'(hlt), 32'h0);
        chk("t1_rd_data", 32'(rd_data), 32'd42);
        tick(); clear_in();

        // T2: write RIGHT -7, ack held off.
        issue(0, 1, 0, 1, -7);
        for (int i = 0; i < 5; i++) begin
            tick(); req = 0; @(negedge clk);
            chk("t2_out_valid", 32'(out_valid), 32'h2);
            chk("t2_out_data", 32'($signed(out_data)), 32'(-7));
        end
        tick(); out_ack = 4'b0010; @(negedge clk);
        chk("t2_out_valid_ack", 32'(out_valid), 32'h2);
        tick(); out_ack = 0; @(negedge clk);
        chk("t2_ackw", 32'(ackw), 32'h1);
        chk("t2_rd_data_kept", 32'(rd_data), 32'd42);
        tick();

        // T3: ANY picks LEFT over UP/DOWN; LAST then waits on LEFT only.
        in_valid = 4'b1101; set_word(0, 1); set_word(2, 2); set_word(3, 123);
        issue(1, 0, 4, 0, 0);
        tick(); req = 0; @(negedge clk);
        chk("t3_any_ack", 32'(in_ack), 32'h8);
        tick(); in_valid = 0; @(negedge clk);
        chk("t3_rd_data", 32'(rd_data), 32'd123);
        tick();
        in_valid = 4'b0111; issue(1, 0, 5, 0, 0);
        tick(); req = 0;
        tick(); @(negedge clk);
        chk("t3_last_wait", 32'(in_ack), 32'h0);
        chk("t3_last_hlt", 32'(hlt), 32'h1);
        tick(); in_valid = 4'b1000; set_word(3, 55); @(negedge clk);
        chk("t3_last_ack", 32'(in_ack), 32'h8);
        tick(); in_valid = 0; @(negedge clk);
        chk("t3_last_data", 32'(rd_data), 32'd55);
        tick(); clear_in();

        // T4: MOV UP,DOWN with both neighbours ready.
        in_valid = 4'b0001; set_word(0, 999); out_ack = 4'b0100; issue(1, 1, 0, 2, 0);
        tick(); req = 0; @(negedge clk);
        chk("t4_in_ack", 32'(in_ack), 32'h1);
        tick(); @(negedge clk);
        chk("t4_out_valid", 32'(out_valid), 32'h4);
        chk("t4_out_data", 32'(out_data), 32'd999);
        tick(); @(negedge clk);
        chk("t4_ackw", 32'(ackw), 32'h1);
        tick(); clear_in();

        // T5a: write ANY, only DOWN acks: L, R, U, D offers.
        out_ack = 4'b0100; issue(0, 1, 0, 4, 300);
        tick(); req = 0; @(negedge clk); chk("t5_offer_l", 32'(out_valid), 32'h8);
        tick(); @(negedge clk); chk("t5_offer_r", 32'(out_valid), 32'h2);
        tick(); @(negedge clk); chk("t5_offer_u", 32'(out_valid), 32'h1);
        tick(); @(negedge clk); chk("t5_offer_d", 32'(out_valid), 32'h4);
        tick(); @(negedge clk); chk("t5_ackw", 32'(ackw), 32'h1);
        tick(); clear_in();

        // T6: reset during WR_WAIT.
        issue(0, 1, 0, 0, 5);
        tick(); req = 0;
        tick(); rst = 1; #1;
        chk("t6_out_valid", 32'(out_valid), 32'h0);
        chk("t6_hlt", 32'(hlt), 32'h0);
        chk("t6_ackw", 32'(ackw), 32'h0);
        tick(); @(negedge clk);
        chk("t6_ackw_held", 32'(ackw), 32'h0);
        tick(); rst = 0;
        tick();

        // T5b: non-ANY read, then LAST with no partner yet -> 0 in 2 cycles.
        in_valid = 4'b0001; set_word(0, 77); issue(1, 0, 0, 0, 0);
        tick(); req = 0;
        tick(); in_valid = 0; @(negedge clk);
        chk("t5b_rd_77", 32'(rd_data), 32'd77);
        tick();
        issue(1, 0, 5, 0, 0);
        tick(); req = 0; @(negedge clk);
        chk("t5b_ackw", 32'(ackw), 32'h1);
        chk("t5b_rd_zero", 32'(rd_data), 32'd0);
        tick(); clear_in();

        // Random traffic checked against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            req = ($urandom_range(0, 2) == 0);
            rd_en = 1'($urandom_range(0, 1));
            wr_en = 1'($urandom_range(0, 1));
            rd_sel = 3'($urandom_range(0, 7));
            wr_sel = 3'($urandom_range(0, 7));
            wr_data = DW'(int'($urandom_range(0, 1998)) - 999);
            for (int d = 0; d < 4; d++) begin
                in_valid[d] = ($urandom_range(0, 2) == 0);
                out_ack[d] = ($urandom_range(0, 2) == 0);
                set_word(d, int'($urandom_range(0, 1998)) - 999);
            end
        end
        tick(); rst = 0; clear_in();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
